// File: rtl/cmp_minmax_scheduler.sv
// Frame min/max tracker that time-shares one unsigned magnitude comparator between the
// running-max and running-min checks. Define CMP_MINMAX_ARGIDX_EN to add argmax/argmin ports.

module cmp_minmax_mag #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_big,
    output logic             same,
    output logic             a_small
);
    assign a_big   = (a > b);
    assign same    = (a == b);
    assign a_small = (a < b);
endmodule

module cmp_minmax_scheduler #(
    parameter int WIDTH = 4,
    parameter int COUNT = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val
`ifdef CMP_MINMAX_ARGIDX_EN
    ,
    output logic [CNT_W-1:0] argmax,
    output logic [CNT_W-1:0] argmin
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        ACCEPT,
        CMP_MAX,
        CMP_MIN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             xfer;
    logic             first_load;
    logic             max_load;
    logic             min_load;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_a_big;
    logic             cmp_same;
    logic             cmp_a_small;

    // The single shared comparator: A is always the held sample, B follows the state.
    assign cmp_b = (state_q == CMP_MIN) ? min_q : max_q;

    cmp_minmax_mag #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a       (hold_q),
        .b       (cmp_b),
        .a_big   (cmp_a_big),
        .same    (cmp_same),
        .a_small (cmp_a_small)
    );

    assign xfer       = in_valid & in_ready_q;
    assign first_load = (state_q == FIRST) & xfer;
    // Ties fall through as no-update so the earliest occurrence keeps the result.
    assign max_load   = (state_q == CMP_MAX) & ~cmp_same & ~cmp_a_small;
    assign min_load   = (state_q == CMP_MIN) & ~cmp_same & ~cmp_a_big;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) state_d = FIRST;
            end
            FIRST: begin
                if (xfer) begin
                    max_d   = in_data;
                    min_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    state_d = (COUNT == 1) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                if (xfer) begin
                    hold_d  = in_data;
                    state_d = CMP_MAX;
                end
            end
            CMP_MAX: begin
                if (max_load) max_d = hold_q;
                state_d = CMP_MIN;
            end
            CMP_MIN: begin
                if (min_load) min_d = hold_q;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == COUNT_C - 1'b1) ? DONE : ACCEPT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered versions of the next state's decode.
        in_ready_d = (state_d == FIRST) || (state_d == ACCEPT);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            max_q      <= '0;
            min_q      <= '0;
            hold_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            max_q      <= max_d;
            min_q      <= min_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign max_val  = max_q;
    assign min_val  = min_q;

`ifdef CMP_MINMAX_ARGIDX_EN
    logic [CNT_W-1:0] argmax_q, argmax_d;
    logic [CNT_W-1:0] argmin_q, argmin_d;

    // A sample's frame index equals cnt before the CMP_MIN increment.
    always_comb begin
        argmax_d = argmax_q;
        argmin_d = argmin_q;
        if (first_load) begin
            argmax_d = '0;
            argmin_d = '0;
        end
        if (max_load) argmax_d = cnt_q;
        if (min_load) argmin_d = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            argmax_q <= '0;
            argmin_q <= '0;
        end else begin
            argmax_q <= argmax_d;
            argmin_q <= argmin_d;
        end
    end

    assign argmax = argmax_q;
    assign argmin = argmin_q;
`else
    // Without index tracking, cnt only measures frame length.
`endif

endmodule

// File: tb/tb_cmp_minmax_scheduler.sv
// Directed bench for cmp_minmax_scheduler: a COUNT=8 instance driven from a vector table
// plus hand-written reset/start/handshake sequences, and a COUNT=1 instance.

module tb_cmp_minmax_scheduler;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] min_val;

    logic             start1;
    logic             valid1;
    logic             ready1;
    logic [WIDTH-1:0] data1;
    logic             busy1;
    logic             done1;
    logic [WIDTH-1:0] max1;
    logic [WIDTH-1:0] min1;

`ifdef CMP_MINMAX_ARGIDX_EN
    logic [CNT_W-1:0] argmax;
    logic [CNT_W-1:0] argmin;
    logic [CNT_W-1:0] argmax1;
    logic [CNT_W-1:0] argmin1;
`endif

    cmp_minmax_scheduler #(.WIDTH(WIDTH), .COUNT(8), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .max_val  (max_val),
        .min_val  (min_val)
`ifdef CMP_MINMAX_ARGIDX_EN
        ,
        .argmax   (argmax),
        .argmin   (argmin)
`endif
    );

    cmp_minmax_scheduler #(.WIDTH(WIDTH), .COUNT(1), .CNT_W(CNT_W)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .in_valid (valid1),
        .in_ready (ready1),
        .in_data  (data1),
        .busy     (busy1),
        .done     (done1),
        .max_val  (max1),
        .min_val  (min1)
`ifdef CMP_MINMAX_ARGIDX_EN
        ,
        .argmax   (argmax1),
        .argmin   (argmin1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Samples packed four bits each, sample 0 in the low nibble.
    typedef struct {
        string       name;
        logic [31:0] samples;
        int          exp_max;
        int          exp_min;
        int          exp_amax;
        int          exp_amin;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [5];

    // Drives one frame on the COUNT=8 instance; cycles counts FIRST through DONE inclusive.
    task automatic run_frame(input logic [31:0] s, input bit rnd, input bit hold_start,
                             input int stop_after, output int cycles, output int xfers,
                             output bit timed_out);
        bit go;
        cycles    = 0;
        xfers     = 0;
        timed_out = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 1000; k++) begin
            start = hold_start;
            cycles++;
            if (done === 1'b1 || xfers == stop_after) begin
                timed_out = 1'b0;
                break;
            end
            in_valid = (xfers < 8) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (xfers < 8) in_data = s[xfers*4 +: 4];
            go = in_valid && (in_ready === 1'b1);
            @(negedge clk);
            if (go) xfers++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int  cycles;
        int  xfers;
        bit  tmo;
        int  d0;

        vecs[0] = '{"t1_mixed",   32'h27F0_9193, 15, 0, 5, 4, 23};
        vecs[1] = '{"t2_ties",    32'h5555_5555,  5, 5, 0, 0, 23};
        vecs[2] = '{"descending", 32'h89AB_CDEF, 15, 8, 0, 7, 23};
        vecs[3] = '{"ascending",  32'h7654_3210,  7, 0, 7, 0, 23};
        vecs[4] = '{"pair_ties",  32'h1199_2727,  9, 1, 4, 6, 23};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        start1   = 1'b0;
        valid1   = 1'b0;
        data1    = '0;
        #12;
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_max", max_val, 0);
        check("reset_min", min_val, 0);
`ifdef CMP_MINMAX_ARGIDX_EN
        check("reset_argmax", argmax, 0);
        check("reset_argmin", argmin, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Samples offered in IDLE must not be taken.
        in_valid = 1'b1;
        in_data  = 4'd15;
        repeat (3) @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_no_load", max_val, 0);
        in_valid = 1'b0;

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            run_frame(vecs[v].samples, 1'b0, 1'b0, -1, cycles, xfers, tmo);
            check({vecs[v].name, "_timeout"}, tmo, 0);
            check({vecs[v].name, "_cycles"}, cycles, vecs[v].exp_cycles);
            check({vecs[v].name, "_max"}, max_val, vecs[v].exp_max);
            check({vecs[v].name, "_min"}, min_val, vecs[v].exp_min);
`ifdef CMP_MINMAX_ARGIDX_EN
            check({vecs[v].name, "_argmax"}, argmax, vecs[v].exp_amax);
            check({vecs[v].name, "_argmin"}, argmin, vecs[v].exp_amin);
`endif
            @(negedge clk);
            check({vecs[v].name, "_done_pulses"}, done_cnt - d0, 1);
            check({vecs[v].name, "_done_low"}, done, 0);
            check({vecs[v].name, "_idle_busy"}, busy, 0);
            check({vecs[v].name, "_max_held"}, max_val, vecs[v].exp_max);
        end

        // T3: random in_valid, including offers during the compare states.
        run_frame(vecs[0].samples, 1'b1, 1'b0, -1, cycles, xfers, tmo);
        check("t3_timeout", tmo, 0);
        check("t3_xfers", xfers, 8);
        check("t3_max", max_val, 15);
        check("t3_min", min_val, 0);
`ifdef CMP_MINMAX_ARGIDX_EN
        check("t3_argmax", argmax, 5);
        check("t3_argmin", argmin, 4);
`endif
        @(negedge clk);

        // T4: asynchronous reset after four samples abandons the frame.
        run_frame(vecs[0].samples, 1'b0, 1'b0, 4, cycles, xfers, tmo);
        check("t4_partial_max", max_val, 9);
        check("t4_partial_min", min_val, 1);
        check("t4_partial_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_max", max_val, 0);
        check("t4_rst_min", min_val, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_in_ready", in_ready, 0);
`ifdef CMP_MINMAX_ARGIDX_EN
        check("t4_rst_argmax", argmax, 0);
`endif
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_idle_busy", busy, 0);
        run_frame(vecs[0].samples, 1'b0, 1'b0, -1, cycles, xfers, tmo);
        check("t4_refr_timeout", tmo, 0);
        check("t4_refr_max", max_val, 15);
        check("t4_refr_min", min_val, 0);
        @(negedge clk);

        // T5: start held high through the frame and the DONE cycle.
        d0 = done_cnt;
        run_frame(vecs[4].samples, 1'b0, 1'b1, -1, cycles, xfers, tmo);
        check("t5_timeout", tmo, 0);
        check("t5_cycles", cycles, 23);
        @(negedge clk);
        check("t5_idle_busy", busy, 0);
        check("t5_idle_in_ready", in_ready, 0);
        @(negedge clk);
        start = 1'b0;
        check("t5_restart_busy", busy, 1);
        check("t5_restart_in_ready", in_ready, 1);
        check("t5_one_done", done_cnt - d0, 1);
        run_frame(vecs[2].samples, 1'b0, 1'b0, -1, cycles, xfers, tmo);
        check("t5_next_timeout", tmo, 0);
        check("t5_next_max", max_val, 15);
        check("t5_next_min", min_val, 8);
        @(negedge clk);

        // T6: COUNT=1 goes from the FIRST transfer straight to DONE.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("t6_first_ready", ready1, 1);
        valid1 = 1'b1;
        data1  = 4'd12;
        @(negedge clk);
        valid1 = 1'b0;
        check("t6_done", done1, 1);
        check("t6_max", max1, 12);
        check("t6_min", min1, 12);
`ifdef CMP_MINMAX_ARGIDX_EN
        check("t6_argmax", argmax1, 0);
`endif
        @(negedge clk);
        check("t6_done_low", done1, 0);
        check("t6_idle_busy", busy1, 0);
        check("t6_max_held", max1, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
